pulse_line_driver: RTL and testbench

Transmit-side companion to the slave-board button debouncer. Converts single-cycle event strobes from master logic into clean, fixed-width high pulses on a single output line, separated by a guaranteed low gap. The receiving debounce/one-pulse stage therefore sees exactly one event per strobe. Strobes arriving while a pulse is in flight are queued in a saturating counter, so back-to-back events are serialized rather than merged or lost.

---
 rtl/pulse_line_driver.sv | 125 ++++++++++++
 tb/tb_pulse_line_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_line_driver.sv
// pulse_line_driver
// Turns single-cycle event strobes into fixed-width high pulses on one output
// line, each followed by a guaranteed low gap. Strobes that arrive while a
// pulse is in flight are queued in a saturating counter and serialized.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line low, nothing in flight, waiting for an event
// HIGH  | line high, tmr counts down the hold time
// LOW   | line low, tmr counts down the gap; may chain into HIGH
module pulse_line_driver #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    output logic             line,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_HOLD = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] TMR_GAP  = TMR_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;

    logic start_win;
    logic start;
    logic at_max;
    logic acc;

    // A new pulse may begin from IDLE or on the very last gap cycle, so
    // back-to-back events keep an exact HOLD+GAP period.
    always_comb begin
        start_win = (state == IDLE) || ((state == LOW) && (tmr == TMR_ONE));
        start     = start_win && (trig || (pending != '0));
        at_max    = (pending == PEND_MAX);
        acc       = trig && !(at_max && !start);
    end

    // Phase sequencing: state plus the shared hold/gap down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= HIGH;
                        tmr   <= TMR_HOLD;
                    end
                end
                HIGH: begin
                    if (tmr == TMR_ONE) begin
                        state <= LOW;
                        tmr   <= TMR_GAP;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                LOW: begin
                    if (tmr == TMR_ONE) begin
                        if (start) begin
                            state <= HIGH;
                            tmr   <= TMR_HOLD;
                        end else begin
                            state <= IDLE;
                            tmr   <= '0;
                        end
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

    // Pending queue: +1 per accepted strobe, -1 per pulse start; a start with
    // an empty queue consumes the same-cycle strobe directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (acc && !start) begin
            pending <= pending + PEND_ONE;
        end else if (!acc && start) begin
            pending <= pending - PEND_ONE;
        end
    end

    // Dropped-strobe flag, high for the single cycle after the drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= trig && at_max && !start;
        end
    end

    // The line follows the state register only; trig never reaches it
    // combinationally.
    assign line = (state == HIGH);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_line_driver.sv
// Bench for pulse_line_driver: a default instance (CNT_W=4) and a narrow
// instance (CNT_W=2) see the same strobes. A schedule-based reference model
// predicts every cycle; predictions go through a scoreboard queue.
module tb_pulse_line_driver;

    localparam int H = 8;
    localparam int G = 8;

    logic       clk;
    logic       rst_n;
    logic       trig;
    logic       line, busy, overflow;
    logic [3:0] pending;
    logic       line_s, busy_s, overflow_s;
    logic [1:0] pending_s;

    pulse_line_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .line     (line),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    pulse_line_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(2)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .line     (line_s),
        .busy     (busy_s),
        .pending  (pending_s),
        .overflow (overflow_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit line;
        bit busy;
        int pend;
        bit ovf;
    } obs_t;

    typedef struct {
        obs_t d;
        obs_t s;
    } exp_t;

    typedef struct {
        bit trig;
        bit line;
        bit busy;
        int pend;
    } vec_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: each pulse starts at the first edge that is both
    // requested and at least H+G after the previous start.
    int cur_s[2];
    int pend_m[2];
    bit ovf_m[2];
    int maxp[2] = '{15, 3};
    int n_edge  = 0;

    int rise_s, ovf_cnt_s, high_cnt;
    bit prev_line_s;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            cur_s[m]  = -1000;
            pend_m[m] = 0;
            ovf_m[m]  = 0;
        end
    endtask

    task automatic model_step(input bit t, output exp_t e);
        obs_t o[2];
        n_edge++;
        for (int m = 0; m < 2; m++) begin
            bit free_now, ws;
            free_now = (n_edge >= cur_s[m] + H + G);
            ws       = free_now && (pend_m[m] > 0 || t);
            ovf_m[m] = 0;
            if (t) begin
                if (pend_m[m] == maxp[m] && !ws) ovf_m[m] = 1;
                else pend_m[m]++;
            end
            if (ws) begin
                pend_m[m]--;
                cur_s[m] = n_edge;
            end
            o[m].line = (n_edge >= cur_s[m]) && (n_edge < cur_s[m] + H);
            o[m].busy = (n_edge < cur_s[m] + H + G);
            o[m].pend = pend_m[m];
            o[m].ovf  = ovf_m[m];
        end
        e.d = o[0];
        e.s = o[1];
    endtask

    // One clock: drive trig, push the prediction, sample #1 after the edge
    // and compare against the popped prediction.
    task automatic cycle(input bit t);
        exp_t e;
        trig = t;
        model_step(t, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("line",       int'(line),       int'(e.d.line));
        chk("busy",       int'(busy),       int'(e.d.busy));
        chk("pending",    int'(pending),    e.d.pend);
        chk("overflow",   int'(overflow),   int'(e.d.ovf));
        chk("line_s",     int'(line_s),     int'(e.s.line));
        chk("busy_s",     int'(busy_s),     int'(e.s.busy));
        chk("pending_s",  int'(pending_s),  e.s.pend);
        chk("overflow_s", int'(overflow_s), int'(e.s.ovf));
        if (line_s && !prev_line_s) rise_s++;
        if (overflow_s) ovf_cnt_s++;
        if (line) high_cnt++;
        prev_line_s = line_s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_line"},     int'(line),     0);
        chk({tag, "_busy"},     int'(busy),     0);
        chk({tag, "_pending"},  int'(pending),  0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_line_s"},   int'(line_s),   0);
        chk({tag, "_pend_s"},   int'(pending_s), 0);
    endtask

    vec_t tbl[20];

    initial begin
        // Single strobe at index 0: high for 8 edges, low gap for 8, then idle.
        for (int i = 0; i < 20; i++) begin
            tbl[i].trig = (i == 0);
            tbl[i].line = (i < H);
            tbl[i].busy = (i < H + G);
            tbl[i].pend = 0;
        end

        trig        = 1'b0;
        rst_n       = 1'b0;
        prev_line_s = 1'b0;
        rise_s      = 0;
        ovf_cnt_s   = 0;
        high_cnt    = 0;
        model_reset();

        // Reset held for 3 cycles, then a long quiet period.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(50);
        check_all_zero("idle");

        // Single strobe, table-driven.
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].trig);
            chk("tbl_line",    int'(line),    int'(tbl[i].line));
            chk("tbl_busy",    int'(busy),    int'(tbl[i].busy));
            chk("tbl_pending", int'(pending), tbl[i].pend);
        end
        idle(5);

        // Burst of three strobes, serialized at a 16-cycle period.
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        chk("burst_pending", int'(pending), 2);
        idle(3 * (H + G) + 5);
        chk("burst_done_busy", int'(busy), 0);

        // Held strobe for 6 cycles: narrow instance saturates at 3.
        rise_s    = 0;
        ovf_cnt_s = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1);
        chk("sat_pending_s", int'(pending_s), 3);
        chk("sat_pending",   int'(pending),   5);
        idle(6 * (H + G) + 10);
        chk("sat_ovf_pulses_s", ovf_cnt_s, 2);
        chk("sat_line_pulses_s", rise_s, 4);

        // Strobe landing on the final gap cycle chains straight into HIGH.
        cycle(1'b1);
        idle(H + G - 1);
        chk("lastgap_pre_line", int'(line), 0);
        chk("lastgap_pre_busy", int'(busy), 1);
        cycle(1'b1);
        chk("lastgap_line", int'(line), 1);
        chk("lastgap_busy", int'(busy), 1);
        idle(H + G + 5);

        // Async reset mid-HIGH with two events queued.
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        chk("pre_rst_line",    int'(line),    1);
        chk("pre_rst_pending", int'(pending), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        rst_n    = 1'b1;
        high_cnt = 0;
        cycle(1'b1);
        idle(H + G + 10);
        chk("post_rst_high_cycles", high_cnt, H);
        chk("post_rst_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
